// File: rtl/udp_pkg.sv
// udp_pkg: shared constants and capture FSM state for the receive path
package udp_pkg;
  localparam int FRAME_WIDTH    = 12000;
  localparam int MAX_BYTES      = FRAME_WIDTH / 8;
  localparam int MIN_BYTES      = 14;
  localparam int LEN_WIDTH      = 11;
  localparam int DROP_WIDTH     = 16;
  localparam int MAC_WIDTH      = 48;
  localparam int ETH_HDR_BYTES  = 14;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  typedef enum logic [1:0] {IDLE, CAPTURE, DROP} cap_state_e;
endpackage

// File: rtl/eth_frame_capture_if.sv
// eth_frame_capture_if: MAC receive byte stream in, committed frame buffer out
//   rx_data/rx_valid/rx_last/rx_error : receive beat from the MAC (no backpressure)
//   eth_frame/frame_len/frame_start   : last committed frame, length, one-cycle commit pulse
//   drop_count                        : saturating count of discarded frames
interface eth_frame_capture_if;
  import udp_pkg::*;
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   rx_last;
  logic                   rx_error;
  logic [FRAME_WIDTH-1:0] eth_frame;
  logic [LEN_WIDTH-1:0]   frame_len;
  logic                   frame_start;
  logic [DROP_WIDTH-1:0]  drop_count;
  modport master (
    output rx_data, rx_valid, rx_last, rx_error,
    input  eth_frame, frame_len, frame_start, drop_count
  );
  modport slave (
    input  rx_data, rx_valid, rx_last, rx_error,
    output eth_frame, frame_len, frame_start, drop_count
  );
endinterface

// File: rtl/eth_frame_capture.sv
// eth_frame_capture: assembles MAC receive beats into a flat frame buffer, commits clean frames, drops and counts the rest
//   main_clk : sole clock, rising edge
//   main_rst : asynchronous active-high reset
//   bus      : slave side of eth_frame_capture_if (rx beats in, committed frame out)
module eth_frame_capture
  import udp_pkg::*;
(
  input  logic             main_clk,
  input  logic             main_rst,
  eth_frame_capture_if.slave bus
);
  cap_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [FRAME_WIDTH-1:0] shadow_q, shadow_d;
  logic [FRAME_WIDTH-1:0] frame_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic                   start_q;
  logic [DROP_WIDTH-1:0]  drop_q;
  logic                   commit, drop;
  logic [LEN_WIDTH+2:0]   bit_idx;
  assign bit_idx = {cnt_q, 3'b000};
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    drop     = 1'b0;
    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          shadow_d      = '0;
          shadow_d[7:0] = bus.rx_data;
          cnt_d         = LEN_WIDTH'(1);
          err_d         = bus.rx_error;
          drop          = bus.rx_last;
          state_d       = bus.rx_last ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          if (cnt_q == LEN_WIDTH'(MAX_BYTES)) begin
            // 1501st byte: never stored, frame is oversize
            drop    = bus.rx_last;
            state_d = bus.rx_last ? IDLE : DROP;
          end else begin
            shadow_d[bit_idx +: 8] = bus.rx_data;
            cnt_d = cnt_q + 1'b1;
            err_d = err_q | bus.rx_error;
            if (bus.rx_last) begin
              commit  = !err_d && cnt_d >= LEN_WIDTH'(MIN_BYTES);
              drop    = !commit;
              state_d = IDLE;
            end
          end
        end
        DROP: begin
          drop    = bus.rx_last;
          state_d = bus.rx_last ? IDLE : DROP;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Commit copies shadow_d so the final byte is included and a following frame's clear cannot reach eth_frame
  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      shadow_q <= '0;
      frame_q  <= '0;
      len_q    <= '0;
      start_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      frame_q  <= commit ? shadow_d : frame_q;
      len_q    <= commit ? cnt_d : len_q;
      start_q  <= commit;
      drop_q   <= (drop && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
    end
  end
  assign bus.eth_frame   = frame_q;
  assign bus.frame_len   = len_q;
  assign bus.frame_start = start_q;
  assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_eth_frame_capture.sv
// tb_eth_frame_capture: directed frames with a scoreboard of expected commits checked by an independent monitor
module tb_eth_frame_capture;
  import udp_pkg::*;
  logic main_clk = 1'b0;
  logic main_rst = 1'b1;
  eth_frame_capture_if bus();
  eth_frame_capture dut (.main_clk(main_clk), .main_rst(main_rst), .bus(bus));
  always #5 main_clk = ~main_clk;
  typedef struct {
    int                     len;
    logic [FRAME_WIDTH-1:0] data;
    int                     due;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [FRAME_WIDTH-1:0] last_frame = '0;
  logic [FRAME_WIDTH-1:0] zero_frame = '0;
  int last_len = 0;
  always @(posedge main_clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic chk_frame(input string name, input logic [FRAME_WIDTH-1:0] act, input logic [FRAME_WIDTH-1:0] req);
    int d;
    d = -1;
    for (int i = MAX_BYTES - 1; i >= 0; i--) if (act[i*8 +: 8] !== req[i*8 +: 8]) d = i;
    total++;
    if (d >= 0) begin
      bad++;
      $display("FAIL %s: byte %0d got %02h expected %02h", name, d, act[d*8 +: 8], req[d*8 +: 8]);
    end
  endtask
  always @(negedge main_clk) begin
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      total++;
      bad++;
      $display("FAIL frame_start_missing: none at cycle %0d expected len %0d", sbq[0].due, sbq[0].len);
      void'(sbq.pop_front());
    end
    if (bus.frame_start) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_start_unexpected: pulse at cycle %0d len %0d, none expected", cyc, bus.frame_len);
      end else begin
        mon_e = sbq.pop_front();
        chk("start_cycle", cyc, mon_e.due);
        chk("frame_len", bus.frame_len, mon_e.len);
        chk_frame("eth_frame", bus.eth_frame, mon_e.data);
      end
    end
  end
  function automatic logic [7:0] byte_of(input int i, input int seed);
    return i == 12 ? 8'h08 : i == 13 ? 8'h00 : 8'(i * 7 + seed + 1);
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge main_clk);
      bus.rx_valid = 1'b0;
      bus.rx_last  = 1'b0;
      bus.rx_error = 1'b0;
    end
  endtask
  task automatic send(input int len, input int seed, input int err_at, input int gap_at, input int gap_n, input int stop);
    logic [FRAME_WIDTH-1:0] e;
    logic [7:0] b;
    e = '0;
    for (int i = 0; i < stop; i++) begin
      if (i == gap_at) idle(gap_n);
      @(negedge main_clk);
      b = byte_of(i, seed);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      bus.rx_last  = (i == len - 1);
      bus.rx_error = (i == err_at);
      if (i < MAX_BYTES) e[i*8 +: 8] = b;
    end
    if (stop == len && err_at < 0 && len >= MIN_BYTES && len <= MAX_BYTES) begin
      sbq.push_back('{len, e, cyc + 1});
      last_frame = e;
      last_len   = len;
    end
  endtask
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    bus.rx_error = 1'b0;
    bus.rx_data  = 8'h00;
    #12;
    chk("rst_frame_len", bus.frame_len, 0);
    chk("rst_drop_count", bus.drop_count, 0);
    chk("rst_frame_start", bus.frame_start, 0);
    chk_frame("rst_eth_frame", bus.eth_frame, zero_frame);
    @(negedge main_clk);
    main_rst = 1'b0;
    send(60, 1, -1, -1, 0, 60);
    idle(3);
    chk("ethertype", bus.eth_frame[111:96], 16'h0008);
    chk("drop_after_t1", bus.drop_count, 0);
    send(60, 1, -1, 21, 3, 60);
    idle(3);
    send(10, 5, -1, -1, 0, 10);
    send(1501, 9, -1, -1, 0, 1501);
    send(64, 3, 30, -1, 0, 64);
    idle(3);
    chk("drop_after_t3", bus.drop_count, 3);
    chk("hold_len_t3", bus.frame_len, last_len);
    chk_frame("hold_frame_t3", bus.eth_frame, last_frame);
    send(64, 11, -1, -1, 0, 64);
    send(100, 13, -1, -1, 0, 100);
    idle(3);
    chk("len_after_t4", bus.frame_len, 100);
    send(1500, 17, -1, -1, 0, 1500);
    send(14, 19, -1, -1, 0, 14);
    idle(3);
    send(13, 21, -1, -1, 0, 13);
    idle(3);
    chk("drop_after_runt13", bus.drop_count, 4);
    chk("len_after_runt13", bus.frame_len, 14);
    send(64, 23, -1, -1, 0, 40);
    #2;
    main_rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    #1;
    chk("midrst_frame_len", bus.frame_len, 0);
    chk("midrst_drop_count", bus.drop_count, 0);
    chk("midrst_frame_start", bus.frame_start, 0);
    chk_frame("midrst_eth_frame", bus.eth_frame, zero_frame);
    idle(2);
    @(negedge main_clk);
    main_rst = 1'b0;
    send(64, 29, -1, -1, 0, 64);
    idle(3);
    chk("len_after_t5", bus.frame_len, 64);
    chk("drop_after_t5", bus.drop_count, 0);
    idle(2);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_frame_capture.md
Name: eth_frame_capture

Overview:
Receive-side capture stage that directly feeds the UDP/IP header parser. It accepts the MAC receive byte stream and assembles each frame into a flat FRAME_WIDTH-bit buffer. On a clean end-of-frame it presents the buffer with a one-cycle frame_start pulse. Runt, oversize and errored frames are discarded and counted, never presented.

Parameters:
FRAME_WIDTH, 12000, width of frame buffer in bits (1500 bytes)
MIN_BYTES, 14, minimum accepted frame length in bytes (Ethernet header)
LEN_WIDTH, 11, width of byte counter and frame_len output
DROP_WIDTH, 16, width of saturating drop counter

Ports:
main_clk  input  1  sole clock, rising edge
main_rst  input  1  asynchronous, active-high reset
rx_data  input  8  receive byte, first byte = first byte of destination MAC
rx_valid  input  1  rx_data valid this cycle; no backpressure, every valid beat is consumed
rx_last  input  1  qualifies final byte of frame (meaningful only with rx_valid)
rx_error  input  1  MAC error flag for this beat (meaningful only with rx_valid)
eth_frame  output  FRAME_WIDTH  last committed frame; byte k at bits [8k+7:8k]
frame_len  output  LEN_WIDTH  byte length of committed frame
frame_start  output  1  one-cycle pulse: new eth_frame/frame_len valid this cycle
drop_count  output  DROP_WIDTH  saturating count of discarded frames

Behaviour:
- Reset (async assert, applied immediately): state=IDLE, byte_cnt=0, err_flag=0, shadow buffer=0, eth_frame=0, frame_len=0, frame_start=0, drop_count=0.
- MAX_BYTES = FRAME_WIDTH/8 (1500).
- States: IDLE, CAPTURE, DROP.
- IDLE: first rx_valid beat writes rx_data to shadow byte 0 and clears the rest of shadow to zero. byte_cnt=1, err_flag=rx_error.
  - If rx_last on the same beat: runt, drop (drop_count+1), stay IDLE.
  - Otherwise go to CAPTURE.
- CAPTURE, each rx_valid beat:
  - Write shadow byte[byte_cnt]; byte_cnt+1; err_flag |= rx_error.
  - Cycles with rx_valid=0 are gaps: no change.
- CAPTURE, valid beat when byte_cnt==MAX_BYTES (the 1501st byte): byte is not stored; oversize.
  - If rx_last on that beat: drop and go to IDLE.
  - Otherwise go to DROP.
- CAPTURE, valid beat with rx_last: final length L = byte_cnt+1 (this byte included).
  - Commit if err_flag|rx_error == 0 and MIN_BYTES <= L <= MAX_BYTES.
  - Otherwise drop. Either way go to IDLE.
- DROP: ignore data until a valid beat with rx_last, then drop_count+1 and go to IDLE.
- Commit: on the cycle after the last beat, eth_frame <= shadow (final byte included), frame_len <= L, frame_start=1 for exactly that cycle.
  - Latency: last beat at cycle N gives frame_start high in cycle N+1.
- Holding: eth_frame/frame_len hold until the next commit. Dropped frames never disturb them.
- Padding: bytes k >= frame_len read as zero.
- Back-to-back: a new frame may start on the beat immediately after rx_last. Commit of frame A and capture of byte 0 of frame B in the same cycle must both happen. The shadow clear for B must not corrupt eth_frame (copy uses pre-clear shadow).
- drop_count saturates at all-ones; no wrap.
- Reset mid-frame: partial frame discarded, not counted.

Decomposition:
- Shared package udp_pkg: FRAME_WIDTH, MIN_BYTES, MAC_WIDTH=48, ETH_HDR_BYTES=14, ETHERTYPE_IPV4=16'h0800, capture state enum.
- Single module, no sub-module. The saturating counter is small enough to stay inline.

Test Plan:
1. 60-byte frame, bytes 12/13 = 8'h08/8'h00, no error -> one frame_start pulse 1 cycle after last beat; frame_len=60; eth_frame[111:96]=16'h0008; bytes 60..1499 zero.
2. Same 60-byte frame with rx_valid deasserted 3 cycles between bytes 20 and 21 -> identical eth_frame and frame_len to scenario 1.
3. 10-byte runt, then 1501-byte oversize, then 64-byte frame with rx_error on byte 30 -> no frame_start for any; drop_count=3; eth_frame/frame_len unchanged.
4. Frame A (64 bytes) immediately followed by frame B (100 bytes), no idle beat -> two frame_start pulses; eth_frame shows A intact, then B with frame_len=100.
5. main_rst asserted asynchronously at byte 40 of a frame, released, then clean 64-byte frame -> all outputs 0 during reset; next frame commits with frame_len=64; drop_count=0.
6. Exactly 1500-byte frame, then 14-byte frame -> both commit; frame_len=1500 then 14.
